// File: rtl/mips_if_pkg.sv
// Shared types for the instruction-fetch stage: FSM states, queue entry, reset constants.
package mips_if_pkg;

    localparam int IF_ADDR_W = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [IF_ADDR_W-1:0] RESET_PC_DEF = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_DROP
    } if_state_e;

    typedef struct packed {
        logic [31:0]          instr;
        logic [IF_ADDR_W-1:0] pc4;
    } if_entry_t;

endpackage

// File: rtl/if_queue.sv
// Prefetch FIFO between instruction memory and the IF/ID register.
module if_queue
    import mips_if_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  if_entry_t              din,
    output if_entry_t              head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int PW = $clog2(DEPTH);

    if_entry_t mem_q [DEPTH];
    if_entry_t mem_d [DEPTH];
    logic [PW-1:0] wr_q, wr_d;
    logic [PW-1:0] rd_q, rd_d;
    logic [PW:0] cnt_q, cnt_d;

    assign head  = mem_q[rd_q];
    assign count = cnt_q;
    assign full  = (cnt_q == (PW+1)'(DEPTH));
    assign empty = (cnt_q == '0);

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (flush) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (push) begin
                mem_d[wr_q] = din;
                wr_d = wr_q + 1'b1;
            end
            if (pop) begin
                rd_d = rd_q + 1'b1;
            end
            if (push && !pop) begin
                cnt_d = cnt_q + 1'b1;
            end else if (pop && !push) begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '{default: '0};
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/if_prefetch_unit.sv
// Fetch stage: PC, single-outstanding imem requests, prefetch queue, IF/ID register.
// Define IF_PERF_CNT_EN to add the fetch/bubble/flush performance counters.
module if_prefetch_unit
    import mips_if_pkg::*;
#(
    parameter logic [IF_ADDR_W-1:0] RESET_PC = RESET_PC_DEF,
    parameter int                   QDEPTH   = 2,
    parameter int                   ADDR_W   = IF_ADDR_W
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              Stall,
    input  logic              Redirect,
    input  logic [ADDR_W-1:0] RedirectPC,
    output logic              ImemReq,
    output logic [ADDR_W-1:0] ImemAddr,
    input  logic              ImemRdy,
    input  logic              ImemRvalid,
    input  logic [31:0]       ImemRdata,
    output logic              IfidValid,
    output logic [31:0]       IfidInstr,
    output logic [ADDR_W-1:0] IfidPC
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]       PerfFetchCnt,
    output logic [31:0]       PerfBubbleCnt,
    output logic [31:0]       PerfFlushCnt
`endif
);

    localparam int CW = $clog2(QDEPTH) + 1;

    if_state_e state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic armed_q;
    logic ifid_valid_q, ifid_valid_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic [ADDR_W-1:0] ifid_pc_q, ifid_pc_d;

    logic redir, req, accept, rv_acc, push, pop;
    logic empty, full;
    logic [CW-1:0] count;
    if_entry_t q_din, q_head;

    assign redir  = Redirect && !Stall;
    assign req    = armed_q && (state_q == S_REQ) && (count < CW'(QDEPTH));
    assign accept = req && ImemRdy;
    // Only the response to a live request is usable; a redirect kills it.
    assign rv_acc = ImemRvalid && (state_q == S_WAIT) && !redir;
    assign pop    = !Stall && !redir && !empty;
    assign push   = rv_acc && (Stall || !empty) && (!full || pop);
    assign q_din  = '{instr: ImemRdata, pc4: pc_q};

    if_queue #(.DEPTH(QDEPTH)) u_queue (
        .clk   (Clk),
        .rst_n (Rst_n),
        .push  (push),
        .pop   (pop),
        .flush (redir),
        .din   (q_din),
        .head  (q_head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        if (accept) begin
            pc_d = pc_q + ADDR_W'(4);
        end
        unique case (state_q)
            S_REQ:   if (accept) state_d = S_WAIT;
            S_WAIT:  if (ImemRvalid) state_d = S_REQ;
            S_DROP:  if (ImemRvalid) state_d = S_REQ;
            default: state_d = S_REQ;
        endcase
        if (redir) begin
            pc_d = RedirectPC & ~ADDR_W'(3);
            if (accept) begin
                state_d = S_DROP;
            end else if (state_q != S_REQ && !ImemRvalid) begin
                state_d = S_DROP;
            end else begin
                state_d = S_REQ;
            end
        end
    end

    always_comb begin
        ifid_valid_d = ifid_valid_q;
        ifid_instr_d = ifid_instr_q;
        ifid_pc_d    = ifid_pc_q;
        if (redir) begin
            ifid_valid_d = 1'b0;
            ifid_instr_d = NOP_INSTR;
        end else if (!Stall) begin
            if (!empty) begin
                ifid_valid_d = 1'b1;
                ifid_instr_d = q_head.instr;
                ifid_pc_d    = q_head.pc4;
            end else if (rv_acc) begin
                ifid_valid_d = 1'b1;
                ifid_instr_d = ImemRdata;
                ifid_pc_d    = pc_q;
            end else begin
                ifid_valid_d = 1'b0;
                ifid_instr_d = NOP_INSTR;
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q      <= S_REQ;
            pc_q         <= RESET_PC;
            armed_q      <= 1'b0;
            ifid_valid_q <= 1'b0;
            ifid_instr_q <= NOP_INSTR;
            ifid_pc_q    <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            armed_q      <= 1'b1;
            ifid_valid_q <= ifid_valid_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc_q    <= ifid_pc_d;
        end
    end

    assign ImemReq   = req;
    assign ImemAddr  = pc_q;
    assign IfidValid = ifid_valid_q;
    assign IfidInstr = ifid_instr_q;
    assign IfidPC    = ifid_pc_q;

`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] bubble_cnt_q, bubble_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        fetch_cnt_d  = fetch_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        if (accept && fetch_cnt_q != '1) begin
            fetch_cnt_d = fetch_cnt_q + 32'd1;
        end
        if (!Stall && !redir && !ifid_valid_d && bubble_cnt_q != '1) begin
            bubble_cnt_d = bubble_cnt_q + 32'd1;
        end
        if (redir && flush_cnt_q != '1) begin
            flush_cnt_d = flush_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            fetch_cnt_q  <= '0;
            bubble_cnt_q <= '0;
            flush_cnt_q  <= '0;
        end else begin
            fetch_cnt_q  <= fetch_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign PerfFetchCnt  = fetch_cnt_q;
    assign PerfBubbleCnt = bubble_cnt_q;
    assign PerfFlushCnt  = flush_cnt_q;
`endif

endmodule

// File: tb/tb_if_prefetch_unit.sv
// Directed bench for if_prefetch_unit with a small instruction-memory responder.
module tb_if_prefetch_unit;

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b1;
    logic        Stall = 1'b0;
    logic        Redirect = 1'b0;
    logic [31:0] RedirectPC = '0;
    logic        ImemRdy = 1'b0;
    logic        ImemRvalid = 1'b0;
    logic [31:0] ImemRdata = '0;
    logic        ImemReq;
    logic [31:0] ImemAddr;
    logic        IfidValid;
    logic [31:0] IfidInstr;
    logic [31:0] IfidPC;

    int n_chk = 0;
    int n_fail = 0;
    bit mem_auto = 1'b1;

    always #5 Clk = ~Clk;

    if_prefetch_unit dut (
        .Clk        (Clk),
        .Rst_n      (Rst_n),
        .Stall      (Stall),
        .Redirect   (Redirect),
        .RedirectPC (RedirectPC),
        .ImemReq    (ImemReq),
        .ImemAddr   (ImemAddr),
        .ImemRdy    (ImemRdy),
        .ImemRvalid (ImemRvalid),
        .ImemRdata  (ImemRdata),
        .IfidValid  (IfidValid),
        .IfidInstr  (IfidInstr),
        .IfidPC     (IfidPC)
    );

    function automatic logic [31:0] word(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    // One clock; memory answers an accepted request one cycle later.
    task automatic tick();
        logic acc;
        logic [31:0] a;
        acc = ImemReq && ImemRdy && Rst_n;
        a = ImemAddr;
        @(posedge Clk);
        #1;
        ImemRvalid = 1'b0;
        if (acc && mem_auto) begin
            ImemRvalid = 1'b1;
            ImemRdata = word(a);
        end
    endtask

    task automatic test_reset();
        #2 Rst_n = 1'b0;
        ImemRdy = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        n_chk++; if (ImemReq !== 1'b0) begin n_fail++; $display("FAIL rst_req got %b want 0", ImemReq); end
        n_chk++; if (IfidValid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b want 0", IfidValid); end
        n_chk++; if (IfidInstr !== 32'h0) begin n_fail++; $display("FAIL rst_instr got %h want 0", IfidInstr); end
        n_chk++; if (IfidPC !== 32'h0) begin n_fail++; $display("FAIL rst_pc got %h want 0", IfidPC); end
        Rst_n = 1'b1;
    endtask

    task automatic test_fetch();
        tick();
        n_chk++; if (ImemReq !== 1'b1 || ImemAddr !== 32'h0) begin n_fail++; $display("FAIL fetch_first_req got %b/%h want 1/0", ImemReq, ImemAddr); end
        n_chk++; if (IfidValid !== 1'b0) begin n_fail++; $display("FAIL fetch_early_valid got %b want 0", IfidValid); end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_chk++; if (IfidValid !== 1'b0) begin n_fail++; $display("FAIL fetch_gap%0d got %b want 0", i, IfidValid); end
            tick();
            n_chk++; if (IfidValid !== 1'b1 || IfidInstr !== word(32'(4*i)) || IfidPC !== 32'(4*i+4)) begin
                n_fail++; $display("FAIL fetch_ifid%0d got %b/%h/%h want 1/%h/%h", i, IfidValid, IfidInstr, IfidPC, word(32'(4*i)), 32'(4*i+4));
            end
            if (i < 2) begin
                n_chk++; if (ImemReq !== 1'b1 || ImemAddr !== 32'(4*i+4)) begin n_fail++; $display("FAIL fetch_addr%0d got %b/%h want 1/%h", i, ImemReq, ImemAddr, 32'(4*i+4)); end
            end
        end
    endtask

    task automatic test_stall();
        Stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_chk++; if (IfidValid !== 1'b1 || IfidInstr !== word(32'h8) || IfidPC !== 32'hC) begin
                n_fail++; $display("FAIL stall_hold%0d got %b/%h/%h want 1/%h/c", i, IfidValid, IfidInstr, IfidPC, word(32'h8));
            end
        end
        n_chk++; if (ImemReq !== 1'b0) begin n_fail++; $display("FAIL stall_full_req got %b want 0", ImemReq); end
        Stall = 1'b0;
        tick();
        n_chk++; if (IfidValid !== 1'b1 || IfidInstr !== word(32'hC) || IfidPC !== 32'h10) begin
            n_fail++; $display("FAIL stall_drain0 got %b/%h/%h want 1/%h/10", IfidValid, IfidInstr, IfidPC, word(32'hC));
        end
        n_chk++; if (ImemReq !== 1'b1 || ImemAddr !== 32'h14) begin n_fail++; $display("FAIL stall_req got %b/%h want 1/14", ImemReq, ImemAddr); end
        mem_auto = 1'b0;
        tick();
        n_chk++; if (IfidValid !== 1'b1 || IfidInstr !== word(32'h10) || IfidPC !== 32'h14) begin
            n_fail++; $display("FAIL stall_drain1 got %b/%h/%h want 1/%h/14", IfidValid, IfidInstr, IfidPC, word(32'h10));
        end
    endtask

    task automatic test_redirect_wait();
        Redirect = 1'b1;
        RedirectPC = 32'h0000_0043;
        tick();
        Redirect = 1'b0;
        n_chk++; if (IfidValid !== 1'b0 || IfidInstr !== 32'h0) begin n_fail++; $display("FAIL redir_bubble got %b/%h want 0/0", IfidValid, IfidInstr); end
        n_chk++; if (ImemReq !== 1'b0) begin n_fail++; $display("FAIL redir_drop_req got %b want 0", ImemReq); end
        ImemRvalid = 1'b1;
        ImemRdata = word(32'h14);
        tick();
        n_chk++; if (IfidValid !== 1'b0 || IfidInstr !== 32'h0) begin n_fail++; $display("FAIL redir_late_word got %b/%h want 0/0", IfidValid, IfidInstr); end
        n_chk++; if (ImemReq !== 1'b1 || ImemAddr !== 32'h40) begin n_fail++; $display("FAIL redir_target got %b/%h want 1/40", ImemReq, ImemAddr); end
        mem_auto = 1'b1;
        tick();
        tick();
        n_chk++; if (IfidValid !== 1'b1 || IfidInstr !== word(32'h40) || IfidPC !== 32'h44) begin
            n_fail++; $display("FAIL redir_first got %b/%h/%h want 1/%h/44", IfidValid, IfidInstr, IfidPC, word(32'h40));
        end
    endtask

    task automatic test_redirect_stall();
        Stall = 1'b1;
        Redirect = 1'b1;
        RedirectPC = 32'h100;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_chk++; if (IfidValid !== 1'b1 || IfidInstr !== word(32'h40) || IfidPC !== 32'h44) begin
                n_fail++; $display("FAIL rs_hold%0d got %b/%h/%h want 1/%h/44", i, IfidValid, IfidInstr, IfidPC, word(32'h40));
            end
            if (i == 1) begin
                n_chk++; if (ImemReq !== 1'b1 || ImemAddr !== 32'h48) begin n_fail++; $display("FAIL rs_pc_kept got %b/%h want 1/48", ImemReq, ImemAddr); end
            end
        end
        Stall = 1'b0;
        tick();
        Redirect = 1'b0;
        n_chk++; if (IfidValid !== 1'b0 || IfidInstr !== 32'h0) begin n_fail++; $display("FAIL rs_flush got %b/%h want 0/0", IfidValid, IfidInstr); end
        n_chk++; if (ImemReq !== 1'b1 || ImemAddr !== 32'h100) begin n_fail++; $display("FAIL rs_target got %b/%h want 1/100", ImemReq, ImemAddr); end
        tick();
        n_chk++; if (IfidValid !== 1'b0) begin n_fail++; $display("FAIL rs_queue_flushed got %b/%h want 0", IfidValid, IfidInstr); end
        tick();
        n_chk++; if (IfidValid !== 1'b1 || IfidInstr !== word(32'h100) || IfidPC !== 32'h104) begin
            n_fail++; $display("FAIL rs_first got %b/%h/%h want 1/%h/104", IfidValid, IfidInstr, IfidPC, word(32'h100));
        end
    endtask

    task automatic test_wrap();
        ImemRdy = 1'b0;
        Redirect = 1'b1;
        RedirectPC = 32'hFFFF_FFFF;
        tick();
        Redirect = 1'b0;
        n_chk++; if (ImemReq !== 1'b1 || ImemAddr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_target got %b/%h want 1/fffffffc", ImemReq, ImemAddr); end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_chk++; if (ImemReq !== 1'b1 || ImemAddr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_stable%0d got %b/%h want 1/fffffffc", i, ImemReq, ImemAddr); end
        end
        ImemRdy = 1'b1;
        tick();
        tick();
        n_chk++; if (IfidValid !== 1'b1 || IfidInstr !== word(32'hFFFF_FFFC) || IfidPC !== 32'h0) begin
            n_fail++; $display("FAIL wrap_ifid got %b/%h/%h want 1/%h/0", IfidValid, IfidInstr, IfidPC, word(32'hFFFF_FFFC));
        end
        n_chk++; if (ImemReq !== 1'b1 || ImemAddr !== 32'h0) begin n_fail++; $display("FAIL wrap_next got %b/%h want 1/0", ImemReq, ImemAddr); end
    endtask

    task automatic test_async_reset();
        mem_auto = 1'b0;
        Stall = 1'b1;
        tick();
        n_chk++; if (IfidValid !== 1'b1) begin n_fail++; $display("FAIL ar_pre got %b want 1", IfidValid); end
        #2 Rst_n = 1'b0;
        #1;
        n_chk++; if (ImemReq !== 1'b0 || IfidValid !== 1'b0) begin n_fail++; $display("FAIL ar_ctl got %b/%b want 0/0", ImemReq, IfidValid); end
        n_chk++; if (IfidInstr !== 32'h0 || IfidPC !== 32'h0) begin n_fail++; $display("FAIL ar_data got %h/%h want 0/0", IfidInstr, IfidPC); end
        Stall = 1'b0;
        mem_auto = 1'b1;
        tick();
        Rst_n = 1'b1;
        ImemRvalid = 1'b1;
        ImemRdata = 32'hBAD0_BAD0;
        tick();
        n_chk++; if (IfidValid !== 1'b0 || IfidInstr !== 32'h0) begin n_fail++; $display("FAIL ar_stray got %b/%h want 0/0", IfidValid, IfidInstr); end
        n_chk++; if (ImemReq !== 1'b1 || ImemAddr !== 32'h0) begin n_fail++; $display("FAIL ar_restart got %b/%h want 1/0", ImemReq, ImemAddr); end
        tick();
        tick();
        n_chk++; if (IfidValid !== 1'b1 || IfidInstr !== word(32'h0) || IfidPC !== 32'h4) begin
            n_fail++; $display("FAIL ar_first got %b/%h/%h want 1/%h/4", IfidValid, IfidInstr, IfidPC, word(32'h0));
        end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_stall();
        test_redirect_wait();
        test_redirect_stall();
        test_wrap();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
